// File: rtl/calc_pkg.sv
// Shared types and seven-segment patterns for the calculator display path.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK  = 7'b1111111;
    localparam seg7_t SEG_MINUS  = 7'b0111111;
    localparam int    BCD_DIGITS = 3;

    function automatic seg7_t digit_seg(input logic [3:0] d);
        seg7_t s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Purpose: BCD nibble plus blank flag to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output seg7_t      seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : digit_seg(bcd);
    end

endmodule

// File: rtl/result_display.sv
// Purpose: two's-complement result to sign-magnitude BCD, multiplexed onto a seven-segment display.
// Latency: N+2 cycles from sampled result_valid to committed digits; seg/an registered one cycle after.
// Backpressure: none; results arriving while busy land in a single newest-wins pending slot.
module result_display
    import calc_pkg::*;
#(
    parameter int N           = 6,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      result,
    input  logic              result_valid,
    output logic              busy,
    output seg7_t             seg,
    output logic [DIGITS-1:0] an
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = 4 * BCD_DIGITS;

    state_t            state;
    state_t            state_nxt;
    logic [N-1:0]      cap;
    logic [N-1:0]      mag;
    logic              sign;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [CW-1:0]     cnt;
    logic              pend_vld;
    logic [N-1:0]      pend_dat;
    logic              disp_sign;
    logic [BW-1:0]     disp_bcd;
    logic [IW-1:0]     idx;
    logic [RW-1:0]     rcnt;
    seg7_t             dseg [BCD_DIGITS];
    logic              dblank [BCD_DIGITS];
    seg7_t             seg_nxt;
    logic [DIGITS-1:0] an_nxt;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (result_valid) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(N - 1)) state_nxt = DONE;
            DONE:    state_nxt = (pend_vld || result_valid) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction applied before every shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap       <= '0;
            mag       <= '0;
            sign      <= 1'b0;
            bcd       <= '0;
            cnt       <= '0;
            pend_vld  <= 1'b0;
            pend_dat  <= '0;
            disp_sign <= 1'b0;
            disp_bcd  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (result_valid) cap <= result;
                end
                LOAD: begin
                    sign <= cap[N-1];
                    mag  <= cap[N-1] ? (~cap + 1'b1) : cap;
                    bcd  <= '0;
                    cnt  <= '0;
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    cnt        <= cnt + 1'b1;
                end
                DONE: begin
                    disp_sign <= sign;
                    disp_bcd  <= bcd;
                    if (pend_vld)          cap <= pend_dat;
                    else if (result_valid) cap <= result;
                end
                default: ;
            endcase

            // A value arriving in DONE with the slot empty goes straight to cap instead.
            if (busy && result_valid && !(state == DONE && !pend_vld)) begin
                pend_vld <= 1'b1;
                pend_dat <= result;
            end else if (state == DONE && pend_vld) begin
                pend_vld <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_dec
            if (g == 0) begin : g_ones
                assign dblank[g] = 1'b0;
            end else begin : g_upper
                assign dblank[g] = (disp_bcd[BW-1:4*g] == '0);
            end
            seg7_decoder u_dec (
                .bcd   (disp_bcd[4*g +: 4]),
                .blank (dblank[g]),
                .seg   (dseg[g])
            );
        end
    endgenerate

    always_comb begin
        seg_nxt = SEG_BLANK;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (int'(idx) == i) seg_nxt = dseg[i];
        end
        if (int'(idx) == DIGITS - 1) begin
            seg_nxt = (disp_sign && disp_bcd != '0) ? SEG_MINUS : SEG_BLANK;
        end
        an_nxt      = '1;
        an_nxt[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            rcnt <= '0;
            seg  <= digit_seg(4'd0);
            an   <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: vector table of results and expected digits, plus overlap and reset sequences.
module tb_result_display;
    import calc_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] result;
    logic       result_valid;
    logic       busy;
    seg7_t      seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    localparam seg7_t B  = 7'b1111111;
    localparam seg7_t MN = 7'b0111111;
    localparam seg7_t D0 = 7'b1000000;
    localparam seg7_t D1 = 7'b1111001;
    localparam seg7_t D2 = 7'b0100100;
    localparam seg7_t D3 = 7'b0110000;
    localparam seg7_t D5 = 7'b0010010;
    localparam seg7_t D7 = 7'b1111000;

    result_display #(.N(6), .DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .seg          (seg),
        .an           (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] res;
        seg7_t      sgn;
        seg7_t      hun;
        seg7_t      ten;
        seg7_t      one;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watch every digit slot for a full refresh cycle and report the last pattern seen on each.
    task automatic scan(output seg7_t s_one, output seg7_t s_ten, output seg7_t s_hun, output seg7_t s_sgn);
        s_one = 'x; s_ten = 'x; s_hun = 'x; s_sgn = 'x;
        repeat (2) step();
        repeat (20) begin
            @(negedge clk);
            case (an)
                4'b1110: s_one = seg;
                4'b1101: s_ten = seg;
                4'b1011: s_hun = seg;
                4'b0111: s_sgn = seg;
                default: ;
            endcase
        end
    endtask

    task automatic check_display(input string tag, input seg7_t e_sgn, input seg7_t e_hun,
                                 input seg7_t e_ten, input seg7_t e_one);
        seg7_t a_one, a_ten, a_hun, a_sgn;
        scan(a_one, a_ten, a_hun, a_sgn);
        chk({tag, "_ones"},  32'(a_one), 32'(e_one));
        chk({tag, "_tens"},  32'(a_ten), 32'(e_ten));
        chk({tag, "_hund"},  32'(a_hun), 32'(e_hun));
        chk({tag, "_sign"},  32'(a_sgn), 32'(e_sgn));
    endtask

    task automatic pulse(input logic [5:0] v, output int busy_cycles);
        step();
        result       = v;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        busy_cycles  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            else if (busy_cycles > 0) break;
        end
    endtask

    initial begin
        logic [3:0] prev;
        int         trans;
        int         bc;
        logic       v5  [5];
        logic [5:0] r5  [5];

        vecs[0] = '{6'b000101, B,  B, B,  D5};
        vecs[1] = '{6'b100000, MN, B, D3, D2};
        vecs[2] = '{6'b011111, B,  B, D3, D1};
        vecs[3] = '{6'b111111, MN, B, B,  D1};
        vecs[4] = '{6'b000000, B,  B, B,  D0};
        vecs[5] = '{6'b001010, B,  B, D1, D0};
        vecs[6] = '{6'b101100, MN, B, D2, D0};

        rst          = 1'b1;
        result       = '0;
        result_valid = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an",   32'(an),   32'b1110);
        chk("rst_seg",  32'(seg),  32'(D0));
        rst = 1'b0;

        prev  = an;
        trans = 0;
        repeat (16) begin
            step();
            if (an !== prev) begin
                chk("an_rotate", 32'(an), 32'({prev[2:0], prev[3]}));
                trans++;
                prev = an;
            end
        end
        chk("an_transitions", 32'(trans), 32'd3);
        check_display("reset_disp", B, B, B, D0);

        for (int i = 0; i < 7; i++) begin
            pulse(vecs[i].res, bc);
            chk($sformatf("v%0d_busy", i), 32'(bc), 32'd8);
            check_display($sformatf("v%0d", i), vecs[i].sgn, vecs[i].hun, vecs[i].ten, vecs[i].one);
        end

        // Overlap: 3, then -1 and 7 while busy; 7 must replace -1 in the pending slot.
        v5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        r5 = '{6'd3, 6'd0, 6'b111111, 6'd0, 6'd7};
        bc = 0;
        for (int c = 0; c < 5; c++) begin
            result       = r5[c];
            result_valid = v5[c];
            step();
            if (busy) bc++;
        end
        result_valid = 1'b0;
        for (int k = 0; k < 40 && busy; k++) begin
            step();
            if (busy) bc++;
        end
        chk("overlap_busy", 32'(bc), 32'd16);
        check_display("overlap", B, B, B, D7);

        // Reset mid-SHIFT with a pending value drops everything.
        r5 = '{6'd22, 6'd0, 6'd9, 6'd0, 6'd0};
        v5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            result       = r5[c];
            result_valid = v5[c];
            step();
        end
        result_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_an",   32'(an),   32'b1110);
        chk("mid_rst_seg",  32'(seg),  32'(D0));
        bc = 0;
        repeat (30) begin
            step();
            if (busy) bc++;
        end
        chk("post_rst_idle", 32'(bc), 32'd0);
        check_display("post_rst", B, B, B, D0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
